// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types for the two-source TEMAC transmit arbiter.
package eth_tx_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_PRIO = 2'd1,
    GRANT_BULK = 2'd2
  } state_e;

  typedef enum logic {
    SRC_PRIO = 1'b0,
    SRC_BULK = 1'b1
  } src_e;

  // A zero starvation limit still needs one register bit.
  function automatic int starve_width(input int max_starve);
    return (max_starve < 1) ? 1 : $clog2(max_starve + 1);
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Byte-wide AXI4-Stream link used for both arbiter inputs and the TEMAC output.
interface eth_tx_arbiter_if;
  import eth_tx_arbiter_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// Frame-granular prio/bulk arbiter for the TEMAC transmit stream, with a
// starvation limit for bulk and per-source first-beat timestamp pulses.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic             clk,
  input  logic             rst,
  eth_tx_arbiter_if.slave  s_axis_prio,
  eth_tx_arbiter_if.slave  s_axis_bulk,
  eth_tx_arbiter_if.master m_axis,
  output logic             prio_tx_begin,
  output logic             bulk_tx_begin,
  output logic [31:0]      prio_frames,
  output logic [31:0]      bulk_frames
);

  localparam int            SW           = starve_width(MAX_STARVE);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(MAX_STARVE);

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic          first_q;
  logic [31:0]   frames_q [2];

  src_e       sel;
  logic       granted;
  logic       cur_valid;
  logic       cur_last;
  logic       hs;
  logic       bulk_forced;
  logic [1:0] begin_vec;
  logic [1:0] done_vec;

  assign granted     = (state_q == GRANT_PRIO) || (state_q == GRANT_BULK);
  assign sel         = (state_q == GRANT_BULK) ? SRC_BULK : SRC_PRIO;
  assign cur_valid   = granted & ((sel == SRC_BULK) ? s_axis_bulk.tvalid : s_axis_prio.tvalid);
  assign cur_last    = (sel == SRC_BULK) ? s_axis_bulk.tlast : s_axis_prio.tlast;
  assign hs          = cur_valid & m_axis.tready;
  assign bulk_forced = (starve_q >= STARVE_LIMIT);

  // Granted source passes straight through; no skid buffer on this path.
  always_comb begin
    m_axis.tdata       = '0;
    m_axis.tkeep       = 1'b0;
    m_axis.tlast       = 1'b0;
    m_axis.tvalid      = 1'b0;
    s_axis_prio.tready = 1'b0;
    s_axis_bulk.tready = 1'b0;
    case (state_q)
      GRANT_PRIO: begin
        m_axis.tdata       = s_axis_prio.tdata;
        m_axis.tkeep       = s_axis_prio.tkeep;
        m_axis.tlast       = s_axis_prio.tlast;
        m_axis.tvalid      = s_axis_prio.tvalid;
        s_axis_prio.tready = m_axis.tready;
      end
      GRANT_BULK: begin
        m_axis.tdata       = s_axis_bulk.tdata;
        m_axis.tkeep       = s_axis_bulk.tkeep;
        m_axis.tlast       = s_axis_bulk.tlast;
        m_axis.tvalid      = s_axis_bulk.tvalid;
        s_axis_bulk.tready = m_axis.tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      first_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_axis_bulk.tvalid && (!s_axis_prio.tvalid || bulk_forced)) begin
            state_q  <= GRANT_BULK;
            starve_q <= '0;
            first_q  <= 1'b1;
          end else if (s_axis_prio.tvalid) begin
            state_q <= GRANT_PRIO;
            first_q <= 1'b1;
            // Reaching here with bulk pending implies starve_q is below the limit.
            if (s_axis_bulk.tvalid) begin
              starve_q <= starve_q + SW'(1);
            end
          end
        end
        GRANT_PRIO, GRANT_BULK: begin
          if (hs) begin
            first_q <= 1'b0;
            if (cur_last) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign begin_vec[gi] = hs & first_q & (int'(sel) == gi);
    assign done_vec[gi]  = hs & cur_last & (int'(sel) == gi);

    always_ff @(posedge clk) begin
      if (rst) begin
        frames_q[gi] <= '0;
      end else if (done_vec[gi]) begin
        frames_q[gi] <= frames_q[gi] + 32'd1;
      end
    end
  end

  assign prio_tx_begin = begin_vec[int'(SRC_PRIO)];
  assign bulk_tx_begin = begin_vec[int'(SRC_BULK)];
  assign prio_frames   = frames_q[int'(SRC_PRIO)];
  assign bulk_frames   = frames_q[int'(SRC_BULK)];

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Drives two arbiters (starvation limits 4 and 0) with identical stimulus and
// checks every cycle against a behavioural model, plus directed scenarios.
module tb_eth_tx_arbiter;
  import eth_tx_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_tready = 1'b0;
  always #5 clk = ~clk;

  // Index order: [dut][source], source 0 = prio, 1 = bulk.
  logic [7:0]  src_tdata  [2][2];
  logic        src_tkeep  [2][2];
  logic        src_tlast  [2][2];
  logic        src_tvalid [2][2];
  logic        src_tready [2][2];
  logic [7:0]  m_tdata  [2];
  logic        m_tkeep  [2];
  logic        m_tlast  [2];
  logic        m_tvalid [2];
  logic        tx_begin [2][2];
  logic [31:0] frames   [2][2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    eth_tx_arbiter_if p_if ();
    eth_tx_arbiter_if b_if ();
    eth_tx_arbiter_if m_if ();

    assign p_if.tdata  = src_tdata[gi][0];
    assign p_if.tkeep  = src_tkeep[gi][0];
    assign p_if.tlast  = src_tlast[gi][0];
    assign p_if.tvalid = src_tvalid[gi][0];
    assign src_tready[gi][0] = p_if.tready;
    assign b_if.tdata  = src_tdata[gi][1];
    assign b_if.tkeep  = src_tkeep[gi][1];
    assign b_if.tlast  = src_tlast[gi][1];
    assign b_if.tvalid = src_tvalid[gi][1];
    assign src_tready[gi][1] = b_if.tready;
    assign m_if.tready = m_tready;
    assign m_tdata[gi]  = m_if.tdata;
    assign m_tkeep[gi]  = m_if.tkeep;
    assign m_tlast[gi]  = m_if.tlast;
    assign m_tvalid[gi] = m_if.tvalid;

    eth_tx_arbiter #(.MAX_STARVE((gi == 0) ? 4 : 0)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_prio   (p_if),
      .s_axis_bulk   (b_if),
      .m_axis        (m_if),
      .prio_tx_begin (tx_begin[gi][0]),
      .bulk_tx_begin (tx_begin[gi][1]),
      .prio_frames   (frames[gi][0]),
      .bulk_frames   (frames[gi][1])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Source generators
  int s_len [2][2], s_pos [2][2], frames_left [2][2], gap_pos [2][2], gap_left [2][2];
  bit s_active [2][2], hs_src [2][2];
  bit rst_seen;
  int len_min = 1, len_max = 1, valid_pct = 100, tready_mode = 0;

  // Reference model: current grant (0 none, 1 prio, 2 bulk), starvation tally, frame counts
  int          md_g [2];
  int          md_starve [2];
  bit          md_first [2];
  logic [31:0] md_frames [2][2];
  int          max_starve [2] = '{4, 0};

  // Observations
  byte grant_log [2][$];
  int  begin_cyc [2][$];
  int  end_cyc [2][$];
  int  n_beats [2], last_beat_no [2], fr_len [2];
  int  n_begin [2][2];
  bit  saw_begin [2][2], obs_last_hs [2];
  int  cyc = 0;

  task automatic sample_and_check();
    for (int k = 0; k < 2; k++) begin
      logic [14:0] g_vec, e_vec;
      int g, s;
      bit hs, pv, bv;
      g = md_g[k];
      e_vec = '0;
      hs = 1'b0;
      if (g != 0) begin
        s = g - 1;
        hs = src_tvalid[k][s] && m_tready;
        e_vec[14:7]  = src_tdata[k][s];
        e_vec[6]     = src_tkeep[k][s];
        e_vec[5]     = src_tlast[k][s];
        e_vec[4]     = src_tvalid[k][s];
        e_vec[3 - s] = m_tready;
        e_vec[1 - s] = hs && md_first[k];
      end
      g_vec = {m_tdata[k], m_tkeep[k], m_tlast[k], m_tvalid[k],
               src_tready[k][0], src_tready[k][1], tx_begin[k][0], tx_begin[k][1]};
      chk($sformatf("outs_d%0d_c%0d", k, cyc), {49'd0, g_vec}, {49'd0, e_vec});
      chk($sformatf("prio_frames_d%0d_c%0d", k, cyc), {32'd0, frames[k][0]}, {32'd0, md_frames[k][0]});
      chk($sformatf("bulk_frames_d%0d_c%0d", k, cyc), {32'd0, frames[k][1]}, {32'd0, md_frames[k][1]});

      for (int s2 = 0; s2 < 2; s2++) begin
        saw_begin[k][s2] = tx_begin[k][s2];
        if (tx_begin[k][s2]) begin
          n_begin[k][s2]++;
          grant_log[k].push_back((s2 == 0) ? 8'h50 : 8'h42);
          begin_cyc[k].push_back(cyc);
          fr_len[k] = 0;
        end
        hs_src[k][s2] = src_tvalid[k][s2] && src_tready[k][s2];
      end
      obs_last_hs[k] = m_tvalid[k] && m_tready && m_tlast[k];
      if (m_tvalid[k] && m_tready) begin
        n_beats[k]++;
        fr_len[k]++;
        if (m_tlast[k]) begin
          last_beat_no[k] = n_beats[k];
          end_cyc[k].push_back(cyc);
          $display("d%0d frame %s len %0d cycle %0d", k, src_tready[k][0] ? "prio" : "bulk", fr_len[k], cyc);
        end
      end

      if (rst) begin
        md_g[k] = 0;
        md_starve[k] = 0;
        md_first[k] = 1'b0;
        md_frames[k][0] = '0;
        md_frames[k][1] = '0;
      end else if (g == 0) begin
        pv = src_tvalid[k][0];
        bv = src_tvalid[k][1];
        if (bv && (!pv || md_starve[k] >= max_starve[k])) begin
          md_g[k] = 2;
          md_starve[k] = 0;
          md_first[k] = 1'b1;
        end else if (pv) begin
          md_g[k] = 1;
          md_first[k] = 1'b1;
          if (bv) md_starve[k] = (md_starve[k] + 1 > max_starve[k]) ? max_starve[k] : md_starve[k] + 1;
        end
      end else if (hs) begin
        md_first[k] = 1'b0;
        if (src_tlast[k][g - 1]) begin
          md_frames[k][g - 1] = md_frames[k][g - 1] + 32'd1;
          md_g[k] = 0;
        end
      end
    end
    rst_seen = rst;
    cyc++;
  endtask

  task automatic drive();
    case (tready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = !m_tready;
      default: m_tready = ($urandom_range(0, 99) < 70);
    endcase
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        bit held, v;
        held = src_tvalid[k][s] && !hs_src[k][s] && !rst_seen;
        if (rst_seen) begin
          s_active[k][s] = 1'b0;
        end else if (hs_src[k][s]) begin
          s_pos[k][s]++;
          if (s_pos[k][s] >= s_len[k][s]) s_active[k][s] = 1'b0;
        end
        if (!s_active[k][s] && frames_left[k][s] != 0) begin
          s_active[k][s] = 1'b1;
          s_pos[k][s] = 0;
          s_len[k][s] = $urandom_range(len_min, len_max);
          if (frames_left[k][s] > 0) frames_left[k][s]--;
          held = 1'b0;
        end
        if (!s_active[k][s]) begin
          v = 1'b0;
        end else if (held) begin
          v = 1'b1;
        end else if (gap_left[k][s] > 0 && s_pos[k][s] == gap_pos[k][s]) begin
          v = 1'b0;
          gap_left[k][s]--;
        end else begin
          v = ($urandom_range(0, 99) < valid_pct);
        end
        if (v && !held) src_tdata[k][s] = 8'($urandom);
        src_tvalid[k][s] = v;
        src_tkeep[k][s]  = v;
        src_tlast[k][s]  = v && (s_pos[k][s] == s_len[k][s] - 1);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy();
    bit b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (md_g[k] != 0) b = 1'b1;
      for (int s = 0; s < 2; s++) if (s_active[k][s]) b = 1'b1;
    end
    return b;
  endfunction

  task automatic set_all_frames(input int n);
    for (int k = 0; k < 2; k++) for (int s = 0; s < 2; s++) frames_left[k][s] = n;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_idle_timeout"}, {63'd0, busy()}, 64'd0);
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 2; k++) begin
      grant_log[k].delete();
      begin_cyc[k].delete();
      end_cyc[k].delete();
      n_beats[k] = 0;
      last_beat_no[k] = 0;
      n_begin[k][0] = 0;
      n_begin[k][1] = 0;
    end
  endtask

  task automatic do_reset();
    set_all_frames(0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_obs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_tvalid_d%0d", k), {63'd0, m_tvalid[k]}, 64'd0);
      chk($sformatf("rst_prio_frames_d%0d", k), {32'd0, frames[k][0]}, 64'd0);
      chk($sformatf("rst_bulk_frames_d%0d", k), {32'd0, frames[k][1]}, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_order;
    int n;
    exp_order = "PPPPBPPPPBPP";
    for (int k = 0; k < 2; k++) begin
      md_g[k] = 0;
      md_starve[k] = 0;
      md_first[k] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        src_tdata[k][s] = '0;
        src_tkeep[k][s] = 1'b0;
        src_tlast[k][s] = 1'b0;
        src_tvalid[k][s] = 1'b0;
        md_frames[k][s] = '0;
        s_active[k][s] = 1'b0;
        hs_src[k][s] = 1'b0;
        frames_left[k][s] = 0;
        gap_left[k][s] = 0;
      end
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single bulk 64-byte frame, sink always ready
    len_min = 64; len_max = 64; tready_mode = 0; valid_pct = 100;
    for (int k = 0; k < 2; k++) frames_left[k][1] = 1;
    step();
    wait_idle("p1", 200);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("p1_beats_d%0d", k), n_beats[k], 64);
      chk($sformatf("p1_tlast_pos_d%0d", k), last_beat_no[k], 64);
      chk($sformatf("p1_bulk_begin_d%0d", k), n_begin[k][1], 1);
      chk($sformatf("p1_prio_begin_d%0d", k), n_begin[k][0], 0);
      chk($sformatf("p1_bulk_frames_d%0d", k), {32'd0, frames[k][1]}, 64'd1);
    end

    // Continuous contention with 60-byte frames
    do_reset();
    len_min = 60; len_max = 60;
    set_all_frames(-1);
    repeat (760) step();
    set_all_frames(0);
    wait_idle("p2", 400);
    chk("p2_grants_d0", {63'd0, grant_log[0].size() >= 12}, 64'd1);
    chk("p2_grants_d1", {63'd0, grant_log[1].size() >= 12}, 64'd1);
    for (int i = 0; i < 12 && i < grant_log[0].size(); i++)
      chk($sformatf("p2_order_d0_%0d", i), grant_log[0][i], exp_order[i]);
    for (int i = 0; i < 3 && i < grant_log[1].size(); i++)
      chk($sformatf("p2_order_d1_%0d", i), grant_log[1][i], 8'h42);
    for (int i = 0; i < 11 && i + 1 < begin_cyc[0].size() && i < end_cyc[0].size(); i++) begin
      chk($sformatf("p2_gap_%0d", i), begin_cyc[0][i + 1] - end_cyc[0][i], 2);
      chk($sformatf("p2_span_%0d", i), end_cyc[0][i] - begin_cyc[0][i], 59);
    end

    // Backpressure: toggling ready, 3-cycle prio valid gap mid-frame
    do_reset();
    tready_mode = 1;
    for (int k = 0; k < 2; k++) begin
      frames_left[k][0] = 1;
      gap_pos[k][0] = 30;
      gap_left[k][0] = 3;
    end
    step();
    wait_idle("p3", 400);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("p3_beats_d%0d", k), n_beats[k], 60);
      chk($sformatf("p3_prio_begin_d%0d", k), n_begin[k][0], 1);
      chk($sformatf("p3_bulk_begin_d%0d", k), n_begin[k][1], 0);
      chk($sformatf("p3_prio_frames_d%0d", k), {32'd0, frames[k][0]}, 64'd1);
    end

    // Single-beat prio frame
    tready_mode = 0;
    len_min = 1; len_max = 1;
    for (int k = 0; k < 2; k++) frames_left[k][0] = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!saw_begin[0][0] && n < 20);
    chk("p4_begin_seen", {63'd0, saw_begin[0][0]}, 64'd1);
    chk("p4_tlast_same_cycle", {63'd0, obs_last_hs[0]}, 64'd1);
    chk("p4_prio_frames", {32'd0, frames[0][0]}, 64'd2);
    chk("p4_back_to_idle", {63'd0, m_tvalid[0]}, 64'd0);
    wait_idle("p4", 50);

    // Reset at byte 20 of a bulk frame, then a lone prio frame
    do_reset();
    len_min = 64; len_max = 64;
    for (int k = 0; k < 2; k++) frames_left[k][1] = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!(s_active[0][1] && s_pos[0][1] == 20) && n < 100);
    chk("p5_reached_byte20", {63'd0, s_pos[0][1] == 20}, 64'd1);
    set_all_frames(0);
    len_min = 10; len_max = 10;
    for (int k = 0; k < 2; k++) frames_left[k][0] = 1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_obs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("p5_tvalid_d%0d", k), {63'd0, m_tvalid[k]}, 64'd0);
      chk($sformatf("p5_bulk_frames_d%0d", k), {32'd0, frames[k][1]}, 64'd0);
      chk($sformatf("p5_prio_frames_d%0d", k), {32'd0, frames[k][0]}, 64'd0);
    end
    n = 0;
    while (grant_log[0].size() == 0 && n < 50) begin
      step();
      n++;
    end
    chk("p5_first_grant_d0", (grant_log[0].size() > 0) ? grant_log[0][0] : 8'h00, 8'h50);
    chk("p5_first_grant_d1", (grant_log[1].size() > 0) ? grant_log[1][0] : 8'h00, 8'h50);
    wait_idle("p5", 100);

    // Random traffic, short frames, random ready
    do_reset();
    len_min = 1; len_max = 8; valid_pct = 60; tready_mode = 2;
    set_all_frames(-1);
    repeat (3000) step();
    set_all_frames(0);
    wait_idle("p6", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Frame-granular arbiter that shares one TEMAC transmit AXI4-Stream between two requesters.
  - prio: the latency measurer's ping/pong transmitter.
  - bulk: a traffic generator or PS DMA path.
- prio wins contention so latency frames see minimal queueing; a starvation limit guarantees bulk progress.
- Emits a first-byte-accepted pulse per source, used by the measurement coordinator as the transmit timestamp event.

Parameters:
- MAX_STARVE, 4: consecutive prio grants won while bulk was pending before bulk is forced. 0 means bulk wins every contention.

Ports:
- clk  in  1  single clock for all logic and streams
- rst  in  1  synchronous reset, active-high
- s_axis_prio_tdata  in  8  prio frame byte
- s_axis_prio_tkeep  in  1  prio byte valid
- s_axis_prio_tlast  in  1  prio last byte of frame
- s_axis_prio_tvalid  in  1  prio beat valid
- s_axis_prio_tready  out  1  prio beat accepted
- s_axis_bulk_tdata/tkeep/tlast/tvalid/tready: same widths and directions as prio, for bulk
- m_axis_tdata  out  8  to TEMAC
- m_axis_tkeep  out  1  to TEMAC
- m_axis_tlast  out  1  to TEMAC
- m_axis_tvalid  out  1  to TEMAC
- m_axis_tready  in  1  from TEMAC
- prio_tx_begin  out  1  one-cycle pulse: first beat of a prio frame accepted by TEMAC
- bulk_tx_begin  out  1  same, for bulk
- prio_frames  out  32  count of prio frames completed (tlast handshake), wraps
- bulk_frames  out  32  count of bulk frames completed, wraps

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, starve_cnt=0, first=0, both frame counters 0.
  - All outputs 0 while in IDLE.
  - Reset mid-frame truncates the frame immediately: m_axis_tvalid=0 the cycle after. No tlast is emitted and no counter increments.
- States IDLE, GRANT_PRIO, GRANT_BULK. The state register is updated on clk.
- IDLE:
  - m_axis_* = 0, both s_axis_*_tready = 0.
  - Decision uses the tvalid levels seen in that cycle:
    - prio only: go to GRANT_PRIO.
    - bulk only: go to GRANT_BULK.
    - both: GRANT_BULK if starve_cnt >= MAX_STARVE, else GRANT_PRIO.
    - neither: stay.
  - Entering either grant sets first=1.
- GRANT_x:
  - m_axis_tdata/tkeep/tlast/tvalid = s_axis_x_* combinationally.
  - s_axis_x_tready = m_axis_tready. The non-granted source's tready = 0.
  - Handshake = m_axis_tvalid & m_axis_tready.
  - On a handshake with first=1: x_tx_begin=1 for that cycle (combinational from the handshake), then first←0.
  - On a handshake with tlast=1: x_frames+1 (mod 2^32), next state IDLE.
  - A single-beat frame asserts tx_begin and the counter increment in the same cycle.
  - Source tvalid dropping mid-frame only stalls; the grant is held until tlast. No timeout.
- Throughput: one mandatory IDLE bubble cycle between frames. Back-to-back frames cost frame_len+1 cycles.
- starve_cnt:
  - Width $clog2(MAX_STARVE+1), minimum 1 bit.
  - Updated only on the IDLE→grant transition.
  - IDLE→GRANT_PRIO with bulk tvalid=1: starve_cnt+1, saturating at MAX_STARVE.
  - IDLE→GRANT_BULK: starve_cnt←0.
  - IDLE→GRANT_PRIO with bulk tvalid=0: unchanged.
- Outputs while granted are the only combinational paths, from the selected source and m_axis_tready.
- Downstream must tolerate this path; no skid buffer.

Decomposition:
- Package eth_tx_arbiter_pkg: state enum typedef (IDLE, GRANT_PRIO, GRANT_BULK) and a source-select enum (SRC_PRIO, SRC_BULK).
- No sub-module. The per-source frame counter is two instances of trivial logic and stays inline.

Test Plan:
- Single source: bulk sends one 64-byte frame with m_axis_tready=1.
  - m_axis carries 64 bytes with tlast on byte 64.
  - bulk_tx_begin pulses once on the first beat; bulk_frames=1; prio_tx_begin never asserts.
- Contention, MAX_STARVE=4: both sources continuously valid with 60-byte frames, 12 frames observed.
  - Grant order is P,P,P,P,B,P,P,P,P,B,P,P.
  - Every frame is separated by exactly one idle cycle.
- Backpressure: prio 60-byte frame, m_axis_tready toggles 1/0 each cycle, prio tvalid drops for 3 cycles mid-frame.
  - All 60 bytes arrive in order; no bulk byte is interleaved.
  - prio_tx_begin pulses exactly once.
- Single-beat frame: prio sends one beat with tlast=1.
  - prio_tx_begin=1 and prio_frames increments in the same cycle; state returns to IDLE on the next cycle.
- Reset mid-frame: rst=1 at byte 20 of a bulk frame.
  - Next cycle m_axis_tvalid=0, both counters 0, starve_cnt 0.
  - After rst=0, a fresh prio frame is granted first if only prio is valid.
- MAX_STARVE=0 with both sources valid: grant order B,B,B; prio is granted only when bulk tvalid=0 in IDLE.
